// File: rtl/alu_result_collector.sv
// ALU result collector: queues {low, high, sel} results and drains them onto a
// 32-bit valid/ready bus, low word first, updating HI/LO on wide-op completion.
module alu_result_collector #(
   parameter int word_size  = 32,
   parameter int SEL_W      = 6,
   parameter int DEPTH      = 4,
   parameter int WIDE_SEL_A = 2,
   parameter int WIDE_SEL_B = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     res_valid,
   output logic                     res_ready,
   input  logic [word_size-1:0]     res_low,
   input  logic [word_size-1:0]     res_high,
   input  logic [SEL_W-1:0]         res_sel,
   output logic [word_size-1:0]     bus_data,
   output logic                     bus_valid,
   input  logic                     bus_ready,
   output logic                     bus_last,
   output logic [word_size-1:0]     hi_reg,
   output logic [word_size-1:0]     lo_reg,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [SEL_W-1:0] SEL_A = SEL_W'(WIDE_SEL_A);
   localparam logic [SEL_W-1:0] SEL_B = SEL_W'(WIDE_SEL_B);

   typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

   state_t               state;
   logic [word_size-1:0] mem_low  [DEPTH];
   logic [word_size-1:0] mem_high [DEPTH];
   logic [SEL_W-1:0]     mem_sel  [DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        nxt_ptr;

   logic                 push;
   logic                 pop;
   logic [word_size-1:0] head_low;
   logic [word_size-1:0] head_high;
   logic [SEL_W-1:0]     head_sel;
   logic [word_size-1:0] nxt_low;
   logic [SEL_W-1:0]     nxt_sel;
   logic                 nxt_avail;

   function automatic logic is_wide(input logic [SEL_W-1:0] s);
      return (s == SEL_A) || (s == SEL_B);
   endfunction

   assign res_ready = (count < CW'(DEPTH));
   assign push      = res_valid && res_ready;
   assign pop       = bus_valid && bus_ready && bus_last;

   assign head_low  = mem_low[rd_ptr];
   assign head_high = mem_high[rd_ptr];
   assign head_sel  = mem_sel[rd_ptr];
   assign nxt_ptr   = rd_ptr + PW'(1);

   // With only the head queued, the follow-on entry is the one being pushed
   // this very edge and is not in storage yet, so take it straight off the input.
   assign nxt_avail = (count != CW'(1)) || push;
   assign nxt_low   = (count == CW'(1)) ? res_low : mem_low[nxt_ptr];
   assign nxt_sel   = (count == CW'(1)) ? res_sel : mem_sel[nxt_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_low[wr_ptr]  <= res_low;
         mem_high[wr_ptr] <= res_high;
         mem_sel[wr_ptr]  <= res_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= nxt_ptr;
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bus_data  <= '0;
         bus_valid <= 1'b0;
         bus_last  <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (count != '0) begin
                  bus_data  <= head_low;
                  bus_valid <= 1'b1;
                  bus_last  <= !is_wide(head_sel);
                  state     <= SEND_LO;
               end
            end
            SEND_LO: begin
               if (bus_ready) begin
                  if (bus_last) begin
                     if (nxt_avail) begin
                        bus_data <= nxt_low;
                        bus_last <= !is_wide(nxt_sel);
                        state    <= SEND_LO;
                     end else begin
                        bus_valid <= 1'b0;
                        bus_last  <= 1'b0;
                        state     <= IDLE;
                     end
                  end else begin
                     bus_data <= head_high;
                     bus_last <= 1'b1;
                     state    <= SEND_HI;
                  end
               end
            end
            SEND_HI: begin
               if (bus_ready) begin
                  lo_reg <= head_low;
                  hi_reg <= head_high;
                  if (nxt_avail) begin
                     bus_data <= nxt_low;
                     bus_last <= !is_wide(nxt_sel);
                     state    <= SEND_LO;
                  end else begin
                     bus_valid <= 1'b0;
                     bus_last  <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: begin
               bus_valid <= 1'b0;
               bus_last  <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
